// File: rtl/spike_event_packer.sv
`default_nettype none
// ============================================================================
// Module  : spike_event_packer
// Brief   : Packs ON/OFF spike events with a relative timestamp (count of
//           empty samples since the last packed event) into EW-bit words,
//           buffers them in a small FIFO and drains them over valid/ready.
//           A sticky flag reports events dropped while the FIFO was full.
// Revision: 1.0 - initial release
// ============================================================================
module spike_event_packer #(
   parameter int TS_W  = 6,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [1:0]                 spike,
   input  logic                       out_ready,
   input  logic                       clr_ovf,
   output logic                       out_valid,
   output logic [TS_W+1:0]            out_data,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       overflow
);

   localparam int EW = TS_W + 2;
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   localparam logic [PW-1:0]   c_PTR_ONE = PW'(1);
   localparam logic [LW-1:0]   c_LVL_ONE = LW'(1);
   localparam logic [LW-1:0]   c_FULL    = LW'(DEPTH);
   localparam logic [TS_W-1:0] c_GAP_MAX = '1;

   logic [EW-1:0]   r_mem [DEPTH];
   logic [PW-1:0]   r_wptr;
   logic [PW-1:0]   r_rptr;
   logic [LW-1:0]   r_count;
   logic [TS_W-1:0] r_gap;
   logic            r_overflow;

   logic            w_is_event;
   logic            w_gap_full;
   logic            w_push;
   logic [EW-1:0]   w_push_data;
   logic            w_full;
   logic            w_pop;
   logic            w_accept;
   logic            w_drop;

   // Classify the current sample and decide what, if anything, gets pushed.
   // An idle marker closes a run of 2^TS_W empty samples so the timestamp
   // field never wraps silently.
   always_comb begin
      w_is_event  = (spike == 2'b01) || (spike == 2'b10);
      w_gap_full  = (r_gap == c_GAP_MAX);
      w_push      = in_valid && (w_is_event || w_gap_full);
      w_push_data = w_is_event ? {spike, r_gap} : {2'b00, c_GAP_MAX};
      w_full      = (r_count == c_FULL);
      w_pop       = (r_count != '0) && out_ready;
      // A pop in the same cycle frees the slot a full FIFO needs.
      w_accept    = w_push && (!w_full || w_pop);
      w_drop      = w_push && w_full && !w_pop;
   end

   // Gap counter: counts qualified empty samples, restarts on any push attempt.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_gap <= '0;
      end else if (in_valid) begin
         if (w_push) begin
            r_gap <= '0;
         end else begin
            r_gap <= r_gap + c_GAP_MAX'(1);
         end
      end
   end

   // FIFO storage; contents need no reset because r_count gates visibility.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem[r_wptr] <= w_push_data;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_accept) begin
            r_wptr <= r_wptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + c_PTR_ONE;
         end
         case ({w_accept, w_pop})
            2'b10:   r_count <= r_count + c_LVL_ONE;
            2'b01:   r_count <= r_count - c_LVL_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky overflow: a drop this cycle wins over a concurrent clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clr_ovf) begin
         r_overflow <= 1'b0;
      end
   end

   assign out_valid  = (r_count != '0);
   assign out_data   = r_mem[r_rptr];
   assign fifo_level = r_count;
   assign overflow   = r_overflow;

endmodule
`default_nettype wire
